// File: rtl/hangy_pkg.sv
// Shared constants, types and helpers for the hangy player-side guess encoder.
package hangy_pkg;

   localparam int unsigned WORD_W      = 12;
   localparam int unsigned CODE_W      = 5;
   localparam int unsigned STATUS_W    = 7;
   localparam int unsigned NUM_LETTERS = 26;
   localparam int unsigned STROBE_BIT  = 5;

   localparam logic [7:0]        KEY_ENTER  = 8'h0D;
   localparam logic [7:0]        ASCII_LC_A = 8'h61;
   localparam logic [7:0]        ASCII_UC_A = 8'h41;
   localparam logic [CODE_W-1:0] START_CODE = 5'd31;

   typedef enum logic [1:0] {IDLE, DRIVE, HOLD} guess_state_e;
   typedef enum logic [1:0] {K_LETTER, K_START, K_BAD} key_kind_e;

   // Strobed guess word: strobe at STROBE_BIT, code in the low bits, upper bits zero.
   function automatic logic [WORD_W-1:0] make_guess(input logic [CODE_W-1:0] code);
      logic [WORD_W-1:0] w;
      w             = '0;
      w[STROBE_BIT] = 1'b1;
      w[CODE_W-1:0] = code;
      return w;
   endfunction

   function automatic logic [2:0] popcount5(input logic [4:0] v);
      logic [2:0] sum;
      sum = '0;
      for (int i = 0; i < 5; i++) sum = sum + 3'(v[i]);
      return sum;
   endfunction

endpackage

// File: rtl/guess_classify.sv
// Combinational ASCII keystroke classifier: letter (case-folded), start command, or bad key.
module guess_classify
   import hangy_pkg::*;
(
   input  logic [7:0]        i_key,
   output key_kind_e         o_kind,
   output logic [CODE_W-1:0] o_idx
);

   logic w_is_lc;
   logic w_is_uc;

   assign w_is_lc = (i_key >= ASCII_LC_A) && (i_key <= 8'h7A);
   assign w_is_uc = (i_key >= ASCII_UC_A) && (i_key <= 8'h5A);

   always_comb begin
      o_kind = K_BAD;
      o_idx  = '0;
      if (w_is_lc) begin
         o_kind = K_LETTER;
         o_idx  = CODE_W'(i_key - ASCII_LC_A);
      end else if (w_is_uc) begin
         o_kind = K_LETTER;
         o_idx  = CODE_W'(i_key - ASCII_UC_A);
      end else if (i_key == KEY_ENTER) begin
         o_kind = K_START;
         o_idx  = START_CODE;
      end
   end

endmodule

// File: rtl/guess_encoder.sv
// Player-side front end for the hangy controller: keystrokes in, spaced strobed guesses out,
// repeat suppression, and registered game-status flags.
module guess_encoder
   import hangy_pkg::*;
#(
   parameter int unsigned GAP_CYCLES = 8
) (
   input  logic                clk,
   input  logic                reset,
   input  logic [7:0]          key_data,
   input  logic                key_valid,
   output logic                key_ready,
   output logic [WORD_W-1:0]   chip_input,
   input  logic [STATUS_W-1:0] chip_output,
   output logic                game_won,
   output logic                game_lost,
   output logic [2:0]          letters_found,
   output logic                dup_pulse,
   output logic                bad_key_pulse
);

   localparam int unsigned CNT_W = $clog2(GAP_CYCLES + 1);

   guess_state_e             r_state;
   logic [CNT_W-1:0]         r_gap_cnt;
   logic [NUM_LETTERS-1:0]   r_used_mask;
   logic [WORD_W-1:0]        r_chip_input;
   logic                     r_key_ready;
   logic                     r_game_won;
   logic                     r_game_lost;
   logic [2:0]               r_letters_found;
   logic                     r_dup_pulse;
   logic                     r_bad_key_pulse;

   key_kind_e                w_kind;
   logic [CODE_W-1:0]        w_idx;
   logic                     w_game_over;
   logic                     w_accept;

   guess_classify u_classify (
      .i_key  (key_data),
      .o_kind (w_kind),
      .o_idx  (w_idx)
   );

   assign w_game_over = r_game_won | r_game_lost;
   assign w_accept    = key_valid & r_key_ready;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state         <= IDLE;
         r_gap_cnt       <= '0;
         r_used_mask     <= '0;
         r_chip_input    <= '0;
         r_key_ready     <= 1'b0;
         r_game_won      <= 1'b0;
         r_game_lost     <= 1'b0;
         r_letters_found <= '0;
         r_dup_pulse     <= 1'b0;
         r_bad_key_pulse <= 1'b0;
      end else begin
         r_game_won      <= chip_output[5];
         r_game_lost     <= chip_output[6];
         r_letters_found <= popcount5(chip_output[4:0]);
         r_dup_pulse     <= 1'b0;
         r_bad_key_pulse <= 1'b0;

         case (r_state)
            IDLE: begin
               r_key_ready  <= 1'b1;
               r_chip_input <= '0;
               if (w_accept) begin
                  case (w_kind)
                     K_LETTER: begin
                        if (!w_game_over && r_used_mask[w_idx]) begin
                           r_dup_pulse <= 1'b1;
                        end else begin
                           // After game over any letter restarts the controller, so the mask starts fresh.
                           if (w_game_over) r_used_mask <= '0;
                           else             r_used_mask[w_idx] <= 1'b1;
                           r_chip_input <= make_guess(w_idx);
                           r_key_ready  <= 1'b0;
                           r_state      <= DRIVE;
                        end
                     end
                     K_START: begin
                        r_used_mask  <= '0;
                        r_chip_input <= make_guess(START_CODE);
                        r_key_ready  <= 1'b0;
                        r_state      <= DRIVE;
                     end
                     default: r_bad_key_pulse <= 1'b1;
                  endcase
               end
            end
            DRIVE: begin
               r_chip_input <= '0;
               r_key_ready  <= 1'b0;
               r_gap_cnt    <= CNT_W'(GAP_CYCLES);
               r_state      <= HOLD;
            end
            HOLD: begin
               r_chip_input <= '0;
               r_gap_cnt    <= r_gap_cnt - CNT_W'(1);
               if (r_gap_cnt == CNT_W'(1)) begin
                  r_key_ready <= 1'b1;
                  r_state     <= IDLE;
               end
            end
            default: begin
               r_chip_input <= '0;
               r_key_ready  <= 1'b0;
               r_state      <= IDLE;
            end
         endcase
      end
   end

   assign key_ready     = r_key_ready;
   assign chip_input    = r_chip_input;
   assign game_won      = r_game_won;
   assign game_lost     = r_game_lost;
   assign letters_found = r_letters_found;
   assign dup_pulse     = r_dup_pulse;
   assign bad_key_pulse = r_bad_key_pulse;

endmodule

// File: tb/tb_guess_encoder.sv
// Directed bench for guess_encoder: strobe timing, start, duplicates, bad keys, game-over and reset abort.
module tb_guess_encoder;

   logic        clk;
   logic        reset;
   logic [7:0]  key_data;
   logic        key_valid;
   logic        key_ready;
   logic [11:0] chip_input;
   logic [6:0]  chip_output;
   logic        game_won;
   logic        game_lost;
   logic [2:0]  letters_found;
   logic        dup_pulse;
   logic        bad_key_pulse;

   int total = 0;
   int bad   = 0;

   guess_encoder #(.GAP_CYCLES(8)) dut (
      .clk           (clk),
      .reset         (reset),
      .key_data      (key_data),
      .key_valid     (key_valid),
      .key_ready     (key_ready),
      .chip_input    (chip_input),
      .chip_output   (chip_output),
      .game_won      (game_won),
      .game_lost     (game_lost),
      .letters_found (letters_found),
      .dup_pulse     (dup_pulse),
      .bad_key_pulse (bad_key_pulse)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Present one key for a single edge; afterwards we sit in the cycle following the accept edge.
   task automatic send(input logic [7:0] k);
      key_data  = k;
      key_valid = 1'b1;
      step();
      key_valid = 1'b0;
   endtask

   // From the DRIVE cycle: 8 quiet HOLD cycles, then ready again.
   task automatic finish_gap(input string tag);
      for (int i = 0; i < 8; i++) begin
         step();
         chk({tag, "_gap_chip"}, 32'(chip_input), 32'h0);
         chk({tag, "_gap_rdy"}, 32'(key_ready), 32'h0);
      end
      step();
      chk({tag, "_ready_back"}, 32'(key_ready), 32'h1);
      chk({tag, "_idle_chip"}, 32'(chip_input), 32'h0);
   endtask

   initial begin
      reset       = 1'b1;
      key_data    = 8'h00;
      key_valid   = 1'b0;
      chip_output = 7'h00;

      // Reset state
      step();
      step();
      chk("rst_chip", 32'(chip_input), 32'h0);
      chk("rst_ready", 32'(key_ready), 32'h0);
      chk("rst_won", 32'(game_won), 32'h0);
      chk("rst_lost", 32'(game_lost), 32'h0);
      chk("rst_found", 32'(letters_found), 32'h0);
      chk("rst_dup", 32'(dup_pulse), 32'h0);
      chk("rst_bad", 32'(bad_key_pulse), 32'h0);
      reset = 1'b0;
      step();
      chk("post_rst_ready", 32'(key_ready), 32'h1);

      // 1: 'n' drives 0x02D for one cycle, then 8 zero cycles
      send(8'h6E);
      chk("n_drive", 32'(chip_input), 32'h02D);
      chk("n_ready_low", 32'(key_ready), 32'h0);
      finish_gap("n1");

      // 2: Enter drives start word and clears the mask
      send(8'h0D);
      chk("start_drive", 32'(chip_input), 32'h03F);
      finish_gap("start");
      send(8'h6E);
      chk("n_after_start", 32'(chip_input), 32'h02D);
      finish_gap("n2");

      // 3: uppercase 'N' is a repeat of 'n'
      send(8'h4E);
      chk("dup_pulse", 32'(dup_pulse), 32'h1);
      chk("dup_no_bad", 32'(bad_key_pulse), 32'h0);
      chk("dup_chip", 32'(chip_input), 32'h0);
      chk("dup_ready", 32'(key_ready), 32'h1);
      step();
      chk("dup_pulse_end", 32'(dup_pulse), 32'h0);

      // 4: '5' is a bad key; keys during HOLD are ignored
      send(8'h35);
      chk("bad_pulse", 32'(bad_key_pulse), 32'h1);
      chk("bad_no_dup", 32'(dup_pulse), 32'h0);
      chk("bad_chip", 32'(chip_input), 32'h0);
      chk("bad_ready", 32'(key_ready), 32'h1);
      step();
      chk("bad_pulse_end", 32'(bad_key_pulse), 32'h0);
      send(8'h62);
      chk("b_drive", 32'(chip_input), 32'h021);
      key_data = 8'h63;
      for (int i = 0; i < 8; i++) begin
         key_valid = (i < 5);
         step();
         chk("hold_ignore_chip", 32'(chip_input), 32'h0);
      end
      key_valid = 1'b0;
      step();
      chk("hold_ignore_ready", 32'(key_ready), 32'h1);
      send(8'h63);
      chk("c_drive", 32'(chip_input), 32'h022);
      finish_gap("c");

      // 5: won game; a used letter is forwarded and the mask cleared
      chip_output = 7'h3F;
      step();
      chk("won_flag", 32'(game_won), 32'h1);
      chk("won_lost", 32'(game_lost), 32'h0);
      chk("won_found", 32'(letters_found), 32'h5);
      send(8'h6E);
      chk("over_fwd", 32'(chip_input), 32'h02D);
      chk("over_no_dup", 32'(dup_pulse), 32'h0);
      finish_gap("over");
      chip_output = 7'h45;
      step();
      chk("lost_flag", 32'(game_lost), 32'h1);
      chk("lost_won", 32'(game_won), 32'h0);
      chk("lost_found", 32'(letters_found), 32'h2);
      chip_output = 7'h00;
      step();
      chk("clear_lost", 32'(game_lost), 32'h0);
      chk("clear_found", 32'(letters_found), 32'h0);
      send(8'h6E);
      chk("n_after_clear", 32'(chip_input), 32'h02D);
      chk("n_after_clear_dup", 32'(dup_pulse), 32'h0);
      finish_gap("n3");

      // 6: reset during HOLD cycle 3 aborts and clears the mask
      send(8'h64);
      chk("d_drive", 32'(chip_input), 32'h023);
      step();
      step();
      step();
      reset = 1'b1;
      step();
      chk("mid_rst_chip", 32'(chip_input), 32'h0);
      chk("mid_rst_ready", 32'(key_ready), 32'h0);
      step();
      reset = 1'b0;
      step();
      chk("mid_rst_release", 32'(key_ready), 32'h1);
      send(8'h64);
      chk("d_after_rst", 32'(chip_input), 32'h023);
      chk("d_after_rst_dup", 32'(dup_pulse), 32'h0);
      finish_gap("d");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
